// File: rtl/arith_inverse_serial.sv
// arith_inverse_serial: bit-serial inverse ("uncompute") unit for the
// reversible arithmetic slice. It recovers operand a from a forward result,
// the original b, cin, cout and select code, one bit per cycle, LSB first.
//
// Optional feature macro: ARITH_INV_CHECK_EN
//   defined   -> chk_err reports final borrow != forward cout
//   undefined -> cout register and compare are omitted, chk_err is 0
//
// Handshake: a request transfers on a rising edge where in_valid && in_ready;
// a result transfers on a rising edge where out_valid && out_ready. Once
// raised, out_valid and the result outputs stay stable until that transfer.
// Only one operation is in flight; in_valid is ignored unless idle.
module arith_inverse_serial #(
  parameter int WIDTH = 32,
  parameter int CNTW  = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       sel,
  input  logic [WIDTH-1:0] res,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             cout,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] a_out,
  output logic             op_err,
  output logic             chk_err,
  output logic [1:0]       dbg_state_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Forward modes that can be undone; everything else is constant/logic.
  localparam logic [1:0] MODE_ADD = 2'b00;  // res = a + b + cin
  localparam logic [1:0] MODE_INC = 2'b01;  // res = a + cin
  localparam logic [1:0] MODE_NEG = 2'b10;  // res = ~a + cin

  localparam logic [CNTW-1:0] LAST_BIT = CNTW'(WIDTH - 1);

  state_t           state_q;
  logic [WIDTH-1:0] res_q;
  logic [WIDTH-1:0] b_q;
  logic [1:0]       mode_q;
  logic             borrow_q;
  logic [CNTW-1:0]  cnt_q;
  logic [WIDTH-1:0] a_q;
  logic             op_err_q;
  logic             chk_err_q;
  logic             out_valid_q;
  logic             in_ready_q;

`ifdef ARITH_INV_CHECK_EN
  logic             cout_q;
`else
  logic             unused_cout;
  assign unused_cout = cout;
`endif

  logic             invertible;
  logic             y_bit;
  logic             diff_bit;
  logic             a_bit_d;
  logic             borrow_d;

  // Classify the incoming select code: only s2=0 arithmetic modes invert.
  always_comb begin
    invertible = 1'b0;
    if (!sel[2] && (sel[1:0] != 2'b11)) begin
      invertible = 1'b1;
    end
  end

  // One full-subtractor slice: res[i] - y[i] - borrow, with the recovered
  // bit inverted when undoing the negate mode.
  always_comb begin
    y_bit    = 1'b0;
    if (mode_q == MODE_ADD) begin
      y_bit = b_q[0];
    end
    diff_bit = res_q[0] ^ y_bit ^ borrow_q;
    borrow_d = (~res_q[0] & (y_bit | borrow_q)) | (y_bit & borrow_q);
    a_bit_d  = diff_bit ^ (mode_q == MODE_NEG);
  end

  // Control FSM with all handshake and result outputs registered.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      res_q       <= '0;
      b_q         <= '0;
      mode_q      <= MODE_ADD;
      borrow_q    <= 1'b0;
      cnt_q       <= '0;
      a_q         <= '0;
      op_err_q    <= 1'b0;
      chk_err_q   <= 1'b0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
`ifdef ARITH_INV_CHECK_EN
      cout_q      <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid && in_ready_q) begin
            res_q      <= res;
            b_q        <= b;
            mode_q     <= sel[1:0];
            in_ready_q <= 1'b0;
`ifdef ARITH_INV_CHECK_EN
            cout_q     <= cout;
`endif
            if (invertible) begin
              borrow_q <= cin;
              cnt_q    <= '0;
              state_q  <= RUN;
            end else begin
              a_q         <= '0;
              op_err_q    <= 1'b1;
              chk_err_q   <= 1'b0;
              out_valid_q <= 1'b1;
              state_q     <= DONE;
            end
          end
        end

        RUN: begin
          // Recovered bits enter at the MSB so a_q is LSB-aligned at the end.
          a_q      <= {a_bit_d, a_q[WIDTH-1:1]};
          res_q    <= {1'b0, res_q[WIDTH-1:1]};
          b_q      <= {1'b0, b_q[WIDTH-1:1]};
          borrow_q <= borrow_d;
          cnt_q    <= cnt_q + 1'b1;
          if (cnt_q == LAST_BIT) begin
            op_err_q    <= 1'b0;
`ifdef ARITH_INV_CHECK_EN
            // A forward overflow (cout=1) must reappear as a final borrow.
            chk_err_q   <= (borrow_d != cout_q);
`else
            chk_err_q   <= 1'b0;
`endif
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end
        end

        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end

        default: begin
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          state_q     <= IDLE;
        end
      endcase
    end
  end

  assign in_ready    = in_ready_q;
  assign out_valid   = out_valid_q;
  assign a_out       = a_q;
  assign op_err      = op_err_q;
  assign chk_err     = chk_err_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_arith_inverse_serial.sv
// Testbench for arith_inverse_serial: directed steps plus randomized
// operations checked against an arithmetic reference model.
module tb_arith_inverse_serial;

  localparam int W = 32;

`ifdef ARITH_INV_CHECK_EN
  localparam bit CHK_EN = 1'b1;
`else
  localparam bit CHK_EN = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [2:0]   sel;
  logic [W-1:0] res;
  logic [W-1:0] b;
  logic         cin;
  logic         cout;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] a_out;
  logic         op_err;
  logic         chk_err;
  logic [1:0]   dbg_state;

  int n_cmp = 0;
  int n_err = 0;

  arith_inverse_serial #(.WIDTH(W), .CNTW(6)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .sel        (sel),
    .res        (res),
    .b          (b),
    .cin        (cin),
    .cout       (cout),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .a_out      (a_out),
    .op_err     (op_err),
    .chk_err    (chk_err),
    .dbg_state_o(dbg_state)
  );

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%h expected 0x%h", tag, obs, exp);
    end
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // Reference model: invert the forward op with whole-word arithmetic.
  function automatic void model(input logic [2:0] s, input logic [W-1:0] r,
                                input logic [W-1:0] bb, input logic c, input logic co,
                                output logic [W-1:0] a, output logic op,
                                output logic ck, output int lat);
    logic brw;
    a = '0; op = 1'b0; ck = 1'b0; lat = W + 1; brw = 1'b0;
    case (s)
      3'b000: begin
        a   = r - bb - W'(c);
        brw = ({1'b0, r} < ({1'b0, bb} + (W+1)'(c)));
      end
      3'b001: begin
        a   = r - W'(c);
        brw = (r < W'(c));
      end
      3'b010: begin
        a   = ~(r - W'(c));
        brw = (r < W'(c));
      end
      default: begin
        op  = 1'b1;
        lat = 1;
      end
    endcase
    if (!op && CHK_EN) ck = (brw != co);
  endfunction

  // ---------------- driver tasks ----------------
  // Called at a falling edge; returns just after the accepting rising edge.
  task automatic accept_op(input logic [2:0] s, input logic [W-1:0] r,
                           input logic [W-1:0] bb, input logic c, input logic co);
    int k;
    k = 0;
    while (!in_ready && k < 200) begin
      @(negedge clk);
      k++;
    end
    check1("in_ready_before_accept", in_ready, 1'b1);
    sel = s; res = r; b = bb; cin = c; cout = co; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    // Inputs only matter at the accepting edge; scramble them afterwards.
    res = $urandom; b = $urandom; cin = 1'(($urandom) & 1); sel = 3'($urandom_range(0, 7));
  endtask

  // Counts rising edges from the accepting edge (edge 1) until out_valid.
  task automatic wait_valid(output int edges);
    edges = 1;
    @(negedge clk);
    while (!out_valid && edges < 3 * W) begin
      @(negedge clk);
      edges++;
    end
  endtask

  task automatic release_out(input string tag);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check1({tag, "_ovalid_drop"}, out_valid, 1'b0);
    check1({tag, "_iready_back"}, in_ready, 1'b1);
  endtask

  task automatic run_op(input string tag, input logic [2:0] s, input logic [W-1:0] r,
                        input logic [W-1:0] bb, input logic c, input logic co,
                        input int hold);
    logic [W-1:0] ea;
    logic         eop, eck;
    int           elat, edges;
    model(s, r, bb, c, co, ea, eop, eck, elat);
    accept_op(s, r, bb, c, co);
    wait_valid(edges);
    check({tag, "_latency"}, 32'(edges), 32'(elat));
    check({tag, "_a_out"}, a_out, ea);
    check1({tag, "_op_err"}, op_err, eop);
    check1({tag, "_chk_err"}, chk_err, eck);
    check1({tag, "_in_ready_busy"}, in_ready, 1'b0);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check({tag, "_hold_a_out"}, a_out, ea);
      check1({tag, "_hold_ovalid"}, out_valid, 1'b1);
    end
    release_out(tag);
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    logic [W-1:0] ea;
    logic         eop, eck;
    int           elat, edges;
    logic [2:0]   rs;
    logic [W-1:0] rr, rb;

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    sel = 3'b000; res = '0; b = '0; cin = 1'b0; cout = 1'b0;
    repeat (3) @(negedge clk);
    check1("reset_in_ready", in_ready, 1'b1);
    check1("reset_out_valid", out_valid, 1'b0);
    check("reset_a_out", a_out, '0);
    check1("reset_op_err", op_err, 1'b0);
    check1("reset_chk_err", chk_err, 1'b0);
    check("reset_state", 32'(dbg_state), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    run_op("add_basic", 3'b000, 32'h0000_0005, 32'h0000_0003, 1'b0, 1'b0, 0);
    run_op("add_wrap",  3'b000, 32'h0000_0001, 32'h0000_0002, 1'b0, 1'b1, 0);
    run_op("neg_mode",  3'b010, 32'hFFFF_FFFB, 32'h1234_5678, 1'b1, 1'b0, 0);
    run_op("inc_mode",  3'b001, 32'h0000_0010, 32'hDEAD_BEEF, 1'b1, 1'b0, 0);
    run_op("sel_011",   3'b011, 32'hCAFE_F00D, 32'h0BAD_0BAD, 1'b1, 1'b1, 0);
    run_op("sel_101",   3'b101, 32'h1111_2222, 32'h3333_4444, 1'b0, 1'b0, 0);
    run_op("cout_mism", 3'b000, 32'h0000_0005, 32'h0000_0003, 1'b0, 1'b1, 0);
    run_op("inc_zero",  3'b001, 32'h0000_0000, 32'h0000_0000, 1'b1, 1'b1, 0);

    // Backpressure: result held, in_valid ignored while waiting in DONE.
    model(3'b000, 32'h0000_0005, 32'h0000_0003, 1'b0, 1'b0, ea, eop, eck, elat);
    accept_op(3'b000, 32'h0000_0005, 32'h0000_0003, 1'b0, 1'b0);
    wait_valid(edges);
    check("hold_latency", 32'(edges), 32'(elat));
    for (int i = 0; i < 10; i++) begin
      sel = 3'b000; res = $urandom; b = $urandom; in_valid = 1'b1;
      @(negedge clk);
      check("hold10_a_out", a_out, ea);
      check1("hold10_ovalid", out_valid, 1'b1);
      check1("hold10_iready", in_ready, 1'b0);
      check1("hold10_op_err", op_err, eop);
      check1("hold10_chk_err", chk_err, eck);
    end
    in_valid = 1'b0;
    release_out("hold10");
    check("hold10_idle_state", 32'(dbg_state), 32'd0);
    run_op("after_hold", 3'b000, 32'h8000_0000, 32'h0000_0001, 1'b1, 1'b0, 0);

    // Reset in the middle of RUN drops the operation without a result.
    accept_op(3'b000, 32'h1234_5678, 32'h0000_1111, 1'b1, 1'b0);
    repeat (12) @(negedge clk);
    check("midrun_state", 32'(dbg_state), 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check1("midrun_rst_iready", in_ready, 1'b1);
    check1("midrun_rst_ovalid", out_valid, 1'b0);
    check("midrun_rst_state", 32'(dbg_state), 32'd0);
    repeat (W + 4) @(negedge clk);
    check1("midrun_no_result", out_valid, 1'b0);
    run_op("after_reset", 3'b010, 32'h0000_0000, 32'h0000_0000, 1'b0, 1'b0, 0);

    // Randomized operations with random backpressure.
    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 9) < 8) rs = 3'($urandom_range(0, 2));
      else                          rs = 3'($urandom_range(3, 7));
      rr = $urandom;
      rb = $urandom;
      if ($urandom_range(0, 3) == 0) rr = rb;
      run_op("random", rs, rr, rb, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             $urandom_range(0, 3));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
